// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops PS/2 scancodes from the receiver FIFO, decodes E0/F0 prefixes and tracks the held key
module ps2_key_ctrl #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       press_evt,
    output logic       release_evt,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        FETCH  = 4'b0010,
        SETTLE = 4'b0100,
        DECODE = 4'b1000
    } state_t;

    state_t state_q, state_d;
    logic [7:0] byte_q, byte_d, key_code_q, key_code_d;
    logic key_valid_q, key_valid_d, key_ext_q, key_ext_d;
    logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic press_evt_q, press_evt_d, release_evt_q, release_evt_d, err_q, err_d;
    logic [3:0] cnt_lo_q, cnt_lo_d, cnt_hi_q, cnt_hi_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic match, pend, tmo, key_byte;

    assign match    = key_valid_q && byte_q == key_code_q && ext_pend_q == key_ext_q;
    assign pend     = ext_pend_q || brk_pend_q;
    assign tmo      = to_cnt_q == TW'(TIMEOUT - 1);
    assign key_byte = byte_q != 8'h00 && byte_q != 8'hFF;

    // Next-state, byte capture, prefix decode, key tracking and prefix timeout
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_ext_d     = key_ext_q;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;
        cnt_lo_d      = cnt_lo_q;
        cnt_hi_d      = cnt_hi_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        err_d         = 1'b0;
        to_cnt_d      = '0;
        case (state_q)
            IDLE: begin
                if (ready) state_d = FETCH;
                else if (pend && tmo) begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    err_d      = 1'b1;
                end else if (pend) to_cnt_d = to_cnt_q + 1'b1;
            end
            FETCH: begin
                byte_d  = data;
                state_d = SETTLE;
            end
            SETTLE: state_d = DECODE;
            DECODE: begin
                state_d = IDLE;
                if (byte_q == 8'hE0) ext_pend_d = 1'b1;
                else if (byte_q == 8'hF0) brk_pend_d = 1'b1;
                else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (key_byte && brk_pend_q && match) begin
                        key_valid_d   = 1'b0;
                        release_evt_d = 1'b1;
                    end else if (key_byte && !brk_pend_q && !match) begin
                        key_code_d  = byte_q;
                        key_ext_d   = ext_pend_q;
                        key_valid_d = 1'b1;
                        press_evt_d = 1'b1;
                        cnt_lo_d    = (cnt_lo_q == 4'd9) ? 4'd0 : cnt_lo_q + 4'd1;
                        cnt_hi_d    = (cnt_lo_q != 4'd9) ? cnt_hi_q : (cnt_hi_q == 4'd9) ? 4'd0 : cnt_hi_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_ext_q     <= 1'b0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            cnt_lo_q      <= '0;
            cnt_hi_q      <= '0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
            err_q         <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_ext_q     <= key_ext_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            cnt_lo_q      <= cnt_lo_d;
            cnt_hi_q      <= cnt_hi_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
            err_q         <= err_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign nextdata_n  = state_q != FETCH;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign press_evt   = press_evt_q;
    assign release_evt = release_evt_q;
    assign cnt_lo      = cnt_lo_q;
    assign cnt_hi      = cnt_hi_q;
    assign err         = err_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: scoreboard bench with a FIFO model and a scancode-level reference model
module tb_ps2_key_ctrl;
    localparam int TO = 8;

    logic       clk = 1'b0, rst = 1'b1, ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       nextdata_n, key_valid, key_ext, press_evt, release_evt, err;
    logic [7:0] key_code;
    logic [3:0] cnt_lo, cnt_hi;

    ps2_key_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ready(ready), .data(data), .nextdata_n(nextdata_n),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .press_evt(press_evt), .release_evt(release_evt),
        .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    int         tests = 0, fails = 0, cyc = 0, last_pop = 0;
    bit         pop_pend = 0;
    bit         m_ext = 0, m_brk = 0, m_valid = 0, m_kext = 0;
    logic [7:0] m_code = 8'h00;
    int         m_cnt = 0;
    logic [7:0] pool[10] = '{8'h1C, 8'h32, 8'h75, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int kind);
        ev_t e;
        e.kind  = 2'(kind);
        e.valid = m_valid;
        e.code  = m_code;
        e.ext   = m_kext;
        e.cnt   = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        return e;
    endfunction

    task automatic send(input logic [7:0] b);
        bit hit;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            hit = m_valid && b == m_code && m_ext == m_kext;
            if (b != 8'h00 && b != 8'hFF) begin
                if (m_brk && hit) begin
                    m_valid = 0;
                    exp_q.push_back(mk(1));
                end else if (!m_brk && !hit) begin
                    m_code  = b;
                    m_kext  = m_ext;
                    m_valid = 1;
                    m_cnt   = (m_cnt + 1) % 100;
                    exp_q.push_back(mk(0));
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
        fifo.push_back(b);
    endtask

    task automatic sendg(input logic [7:0] b);
        send(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic drain;
        int n = 0;
        while ((fifo.size() > 0 || pop_pend) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL drain: FIFO not emptied after %0d cycles, required < 2000", n);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic stall;
        if (m_ext || m_brk) begin
            m_ext = 0;
            m_brk = 0;
            exp_q.push_back(mk(2));
        end
        drain();
        repeat (TO + 6) @(negedge clk);
    endtask

    task automatic model_reset;
        m_ext = 0; m_brk = 0; m_valid = 0; m_kext = 0; m_code = 8'h00; m_cnt = 0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // FIFO model: pops the head one cycle after the pop strobe so data is stable through capture
    initial forever begin
        @(negedge clk);
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        pop_pend = !nextdata_n;
        ready    = fifo.size() > 0;
        data     = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Monitor: pops the scoreboard whenever the DUT reports an event
    initial forever begin
        ev_t e;
        int  kind;
        @(negedge clk);
        cyc++;
        if (!nextdata_n) last_pop = cyc;
        if (!rst && (press_evt || release_evt || err)) begin
            kind = press_evt ? 0 : release_evt ? 1 : 2;
            chk("evt_onehot", 32'(press_evt) + 32'(release_evt) + 32'(err), 1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_evt: got kind %0d code %0h, required no event", kind, key_code);
            end else begin
                e = exp_q.pop_front();
                chk("evt_kind", kind, e.kind);
                chk("key_valid", key_valid, e.valid);
                chk("key_code", key_code, e.code);
                chk("key_ext", key_ext, e.ext);
                chk("cnt", {cnt_hi, cnt_lo}, e.cnt);
                chk("evt_latency", cyc - last_pop, (kind == 2) ? 3 + TO : 3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ndn", nextdata_n, 1);
        chk("rst_outs", {key_valid, key_code, key_ext, press_evt, release_evt, cnt_lo, cnt_hi, err}, 0);
        send(8'h1C);
        drain();
        foreach (pool[i]) if (i < 4) sendg((i == 3) ? 8'hF0 : 8'h1C);
        sendg(8'h1C);
        drain();
        chk("after_release_valid", key_valid, 0);
        chk("after_release_code", key_code, 8'h1C);
        sendg(8'hE0); sendg(8'h75); sendg(8'hF0); sendg(8'h75);
        drain();
        chk("ext_mismatch_held", key_valid, 1);
        sendg(8'hE0); sendg(8'hF0); sendg(8'h75);
        drain();
        chk("ext_release", key_valid, 0);
        pulse_reset();
        for (int i = 0; i < 50; i++) begin
            sendg(8'h1C); sendg(8'hF0); sendg(8'h1C);
            sendg(8'h32); sendg(8'hF0); sendg(8'h32);
        end
        drain();
        chk("cnt_wrap", {cnt_hi, cnt_lo}, 0);
        sendg(8'h1C);
        send(8'hF0);
        stall();
        sendg(8'h1C);
        drain();
        chk("timeout_press_held", key_valid, 1);
        send(8'hE0);
        stall();
        for (int i = 0; i < 300; i++) begin
            sendg(pool[$urandom_range(0, 9)]);
            if ($urandom_range(0, 29) == 0) stall();
        end
        stall();
        fifo.push_back(8'h32);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nextdata_n && n < 50);
        chk("reset_fetch_seen", n < 50, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midfetch_rst_ndn", nextdata_n, 1);
        chk("midfetch_rst_outs", {key_valid, key_code, key_ext, press_evt, release_evt, cnt_lo, cnt_hi, err}, 0);
        repeat (8) @(negedge clk);
        sendg(8'hE0); sendg(8'h75); sendg(8'hE0); sendg(8'hF0); sendg(8'h75); sendg(8'h1C);
        drain();
        chk("post_rst_cnt", {cnt_hi, cnt_lo}, 8'h02);
        chk("exp_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
